result_select_reg: RTL

//   Registered, handshaked successor to the combinational one-hot result selector.

---
 rtl/result_select_reg.sv | 94 +++++++++
 1 files changed

// File: rtl/result_select_reg.sv
// Registered one-hot result selector with a valid/ready output stage.
// Illegal (zero-hot / multi-hot) control vectors are flagged and counted.
module result_select_reg #(
    parameter  int OUT_BITS     = 32,
    parameter  int SIG_COUNT    = 13,
    parameter  int ERR_CNT_BITS = 8,
    localparam int IDX_BITS     = (SIG_COUNT > 1) ? $clog2(SIG_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OUT_BITS*SIG_COUNT-1:0] resultStream,
    input  logic [SIG_COUNT-1:0]          ctrl_signal,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BITS-1:0]           selectedResult,
    output logic [IDX_BITS-1:0]           sel_index,
    output logic                          onehot_err,
    output logic [ERR_CNT_BITS-1:0]       err_count,
    input  logic                          err_clear
);

    logic                    r_outValid;
    logic [OUT_BITS-1:0]     r_selResult;
    logic [IDX_BITS-1:0]     r_selIndex;
    logic                    r_onehotErr;
    logic [ERR_CNT_BITS-1:0] r_errCount;

    logic                    w_found;
    logic                    w_multi;
    logic                    w_illegal;
    logic                    w_accept;
    logic [IDX_BITS-1:0]     w_idx;
    logic [OUT_BITS-1:0]     w_slice;
    logic [ERR_CNT_BITS-1:0] w_errInc;

    assign in_ready = !r_outValid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Descending scan so the lowest set control bit is the one left standing.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_slice = '0;
        for (int i = SIG_COUNT - 1; i >= 0; i--) begin
            if (ctrl_signal[i]) begin
                w_found = 1'b1;
                w_idx   = IDX_BITS'(i);
                w_slice = resultStream[i*OUT_BITS +: OUT_BITS];
            end
        end
    end

    assign w_multi   = (ctrl_signal & (ctrl_signal - SIG_COUNT'(1))) != '0;
    assign w_illegal = !w_found || w_multi;
    assign w_errInc  = (r_errCount == '1) ? r_errCount : r_errCount + ERR_CNT_BITS'(1);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_outValid  <= 1'b0;
            r_selResult <= '0;
            r_selIndex  <= '0;
            r_onehotErr <= 1'b0;
            r_errCount  <= '0;
        end else begin
            if (w_accept) begin
                r_outValid <= w_found;
                if (w_found) begin
                    r_selResult <= w_slice;
                    r_selIndex  <= w_idx;
                end
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end

            // An illegal accept outranks a simultaneous clear and restarts the count at one.
            if (w_accept && w_illegal) begin
                r_onehotErr <= 1'b1;
                r_errCount  <= err_clear ? ERR_CNT_BITS'(1) : w_errInc;
            end else if (err_clear) begin
                r_onehotErr <= 1'b0;
                r_errCount  <= '0;
            end
        end
    end

    assign out_valid      = r_outValid;
    assign selectedResult = r_selResult;
    assign sel_index      = r_selIndex;
    assign onehot_err     = r_onehotErr;
    assign err_count      = r_errCount;

endmodule
